// File: rtl/ixc_gfifo_pg_q.sv
// Buffered gfifo port group: an inbound (si -> ci) and an outbound (co -> so) elastic FIFO.
// With BYPASS set, both directions collapse to plain wires with no storage.

module ixc_gfifo_pg_q_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_vld,
    output logic                       in_rdy,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             vld_r;
    logic             rdy_en_r;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Handshake decode; ready depends only on registered state and flush.
    always_comb begin
        full_s = (cnt_r == CW'(DEPTH));
        in_rdy = rdy_en_r & ~full_s & ~flush;
        push_s = in_vld & in_rdy;
        pop_s  = vld_r & out_rdy & ~flush;
        if (flush) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (push_s & ~pop_s) begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_s & ~push_s) begin
            cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pointers, occupancy and head-valid; flush overrides any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            vld_r    <= 1'b0;
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            cnt_r    <= cnt_nxt_s;
            vld_r    <= (cnt_nxt_s != {CW{1'b0}});
            if (flush) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Storage; cleared on reset so the head reads zero until first written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign out_data = mem_r[rd_ptr_r];
    assign out_vld  = vld_r;
    assign cnt      = cnt_r;
endmodule

module ixc_gfifo_pg_q #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 4,
    parameter int BYPASS = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           si,
    input  logic                       si_vld,
    output logic                       si_rdy,
    output logic [WIDTH-1:0]           ci,
    output logic                       ci_vld,
    input  logic                       ci_rdy,
    input  logic [WIDTH-1:0]           co,
    input  logic                       co_vld,
    output logic                       co_rdy,
    output logic [WIDTH-1:0]           so,
    output logic                       so_vld,
    input  logic                       so_rdy,
    output logic [$clog2(DEPTH+1)-1:0] ci_cnt,
    output logic [$clog2(DEPTH+1)-1:0] so_cnt
);
    localparam int CW = $clog2(DEPTH+1);

    generate
        if (BYPASS != 0) begin : g_bypass
            assign ci     = si;
            assign ci_vld = si_vld;
            assign si_rdy = ci_rdy;
            assign so     = co;
            assign so_vld = co_vld;
            assign co_rdy = so_rdy;
            assign ci_cnt = {CW{1'b0}};
            assign so_cnt = {CW{1'b0}};
        end else begin : g_fifo
            ixc_gfifo_pg_q_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in (
                .clk(clk), .rst_n(rst_n), .flush(flush),
                .in_data(si), .in_vld(si_vld), .in_rdy(si_rdy),
                .out_data(ci), .out_vld(ci_vld), .out_rdy(ci_rdy),
                .cnt(ci_cnt)
            );
            ixc_gfifo_pg_q_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out (
                .clk(clk), .rst_n(rst_n), .flush(flush),
                .in_data(co), .in_vld(co_vld), .in_rdy(co_rdy),
                .out_data(so), .out_vld(so_vld), .out_rdy(so_rdy),
                .cnt(so_cnt)
            );
        end
    endgenerate
endmodule

// File: tb/tb_ixc_gfifo_pg_q.sv
// Bench for ixc_gfifo_pg_q: queue-based reference model for the buffered
// instance, wire-equivalence checks for a BYPASS instance on the same inputs.

module tb_ixc_gfifo_pg_q;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] si = '0, co = '0;
    logic         si_vld = 1'b0, ci_rdy = 1'b0, co_vld = 1'b0, so_rdy = 1'b0;

    logic [W-1:0]  ci, so, b_ci, b_so;
    logic          si_rdy, ci_vld, co_rdy, so_vld;
    logic          b_si_rdy, b_ci_vld, b_co_rdy, b_so_vld;
    logic [CW-1:0] ci_cnt, so_cnt, b_ci_cnt, b_so_cnt;

    ixc_gfifo_pg_q #(.WIDTH(W), .DEPTH(D), .BYPASS(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .si(si), .si_vld(si_vld), .si_rdy(si_rdy),
        .ci(ci), .ci_vld(ci_vld), .ci_rdy(ci_rdy),
        .co(co), .co_vld(co_vld), .co_rdy(co_rdy),
        .so(so), .so_vld(so_vld), .so_rdy(so_rdy),
        .ci_cnt(ci_cnt), .so_cnt(so_cnt)
    );

    ixc_gfifo_pg_q #(.WIDTH(W), .DEPTH(D), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .si(si), .si_vld(si_vld), .si_rdy(b_si_rdy),
        .ci(b_ci), .ci_vld(b_ci_vld), .ci_rdy(ci_rdy),
        .co(co), .co_vld(co_vld), .co_rdy(b_co_rdy),
        .so(b_so), .so_vld(b_so_vld), .so_rdy(so_rdy),
        .ci_cnt(b_ci_cnt), .so_cnt(b_so_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] qi[$];
    logic [W-1:0] qo[$];
    bit ready_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [W-1:0] id, input bit ir,
                         input bit ov, input logic [W-1:0] od, input bit orr, input bit fl);
        si_vld = iv; si = id; ci_rdy = ir;
        co_vld = ov; co = od; so_rdy = orr;
        flush  = fl;
    endtask

    // Called just after a negedge with inputs applied: check, advance model, step one clock.
    task automatic cycle();
        bit irdy, ordy, ipop, opop;
        #2;
        irdy = ready_ok && (qi.size() < D) && !flush;
        ordy = ready_ok && (qo.size() < D) && !flush;
        chk("si_rdy", 32'(si_rdy), 32'(irdy));
        chk("co_rdy", 32'(co_rdy), 32'(ordy));
        chk("ci_vld", 32'(ci_vld), 32'(qi.size() != 0));
        chk("so_vld", 32'(so_vld), 32'(qo.size() != 0));
        chk("ci_cnt", 32'(ci_cnt), 32'(qi.size()));
        chk("so_cnt", 32'(so_cnt), 32'(qo.size()));
        if (qi.size() != 0) chk("ci_data", 32'(ci), 32'(qi[0]));
        if (qo.size() != 0) chk("so_data", 32'(so), 32'(qo[0]));
        chk("byp_ci",  {b_ci, b_ci_vld, b_si_rdy}, {si, si_vld, ci_rdy});
        chk("byp_so",  {b_so, b_so_vld, b_co_rdy}, {co, co_vld, so_rdy});
        chk("byp_cnt", {b_ci_cnt, b_so_cnt}, 32'd0);
        if (flush) begin
            qi.delete();
            qo.delete();
        end else begin
            ipop = (qi.size() != 0) && ci_rdy;
            opop = (qo.size() != 0) && so_rdy;
            if (ipop) void'(qi.pop_front());
            if (opop) void'(qo.pop_front());
            if (si_vld && irdy) qi.push_back(si);
            if (co_vld && ordy) qo.push_back(co);
        end
        @(posedge clk);
        if (rst_n) ready_ok = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state.
        #1;
        chk("rst_vld", {ci_vld, so_vld}, 32'd0);
        chk("rst_data", {ci, so}, 32'd0);
        chk("rst_cnt", {ci_cnt, so_cnt}, 32'd0);
        chk("rst_rdy", {si_rdy, co_rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single push of 0xA5, head held while ci_rdy is low, then popped.
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_ci", 32'(ci), 32'h0000_00A5);
        repeat (3) cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle();

        // Five pushes into a DEPTH-4 FIFO with no pops; the fifth is refused.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            cycle();
        end
        chk("t2_full_cnt", 32'(ci_cnt), 32'd4);
        // Full with push and pop requested together, across pointer wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1, 1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
            cycle();
        end
        // Drain, then build cnt=3 and flush with a coincident push.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (5) cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
            cycle();
        end
        chk("t4_pre_cnt", 32'(ci_cnt), 32'd3);
        drive(1'b1, 8'hEE, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_post_cnt", {ci_cnt, so_cnt}, 32'd0);
        repeat (2) cycle();

        // Asynchronous reset in the middle of a burst on both directions.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            cycle();
        end
        #3 rst_n = 1'b0;
        #1;
        chk("t5_vld", {ci_vld, so_vld}, 32'd0);
        chk("t5_cnt", {ci_cnt, so_cnt}, 32'd0);
        chk("t5_rdy", {si_rdy, co_rdy}, 32'd0);
        qi.delete();
        qo.delete();
        ready_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 24) == 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
